bsram_copy_engine: RTL and testbench
====================================

BSRAM_COPY_ENGINE -- requirements
Module: bsram_copy_engine

Interface
REQ-001 SHALL have parameter CORE, default 0, core index used in scan display.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, memory address width; MEM_DEPTH = 2^ADDR_WIDTH.
REQ-004 SHALL have one clock and a synchronous, active-high reset; the ports are clock and reset.
REQ-005 Ports, in order:
- clock, input, 1, sole clock; all state updates on posedge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle copy request; sampled in IDLE only.
- srcBase, input, ADDR_WIDTH, first source word address.
- dstBase, input, ADDR_WIDTH, first destination word address.
- length, input, ADDR_WIDTH+1, word count.
- busy, output, 1, copy in progress.
- done, output, 1, one-cycle completion pulse.
- readEnable, output, 1, memory read strobe.
- readAddress, output, ADDR_WIDTH, memory read address.
- readData, input, DATA_WIDTH, same-cycle memory read data.
- writeEnable, output, 1, memory write strobe.
- writeAddress, output, ADDR_WIDTH, memory write address.
- writeData, output, DATA_WIDTH, memory write data.
- checksum, output, DATA_WIDTH, XOR of copied words.
- scan, input, 1, enables per-cycle $display trace.

Function
REQ-006 SHALL implement FSM states IDLE, FILL, STREAM, DRAIN, DONE.
REQ-007 IDLE: start=1 with length=0 -> DONE; start=1 with length>=1 -> FILL; srcBase, dstBase and length are latched at that edge.
REQ-008 length > MEM_DEPTH SHALL saturate to MEM_DEPTH at latch time.
REQ-009 FILL: readEnable=1, readAddress=src+0, readData registered into a data register; next state is STREAM if N>1, else DRAIN.
REQ-010 STREAM, cycle k (k=1..N-1): read src+k into the data register; write dst+(k-1) from the data register; after k=N-1, go to DRAIN.
REQ-011 DRAIN: readEnable=0; write dst+(N-1) from the data register; then go to DONE.
REQ-012 DONE: done=1 for exactly one cycle, then IDLE.
REQ-013 writeData SHALL always come from the data register, never combinationally from readData, so no loop forms through memory write-to-read bypass.
REQ-014 Address arithmetic SHALL wrap modulo MEM_DEPTH.
REQ-015 Copy order SHALL be ascending; overlapping ranges follow per-word ascending semantics (memmove not guaranteed).
REQ-016 busy=1 in FILL, STREAM and DRAIN; for N>=1, busy lasts N+1 cycles; for N=0, busy stays 0.
REQ-017 start SHALL be ignored in every state other than IDLE.
REQ-018 readEnable and writeEnable SHALL be 0 in IDLE and DONE; when an enable is 0, its address output is don't-care.
REQ-019 When scan=1, SHALL $display the cycle count, state, read/write strobes, addresses and data every cycle.

Reset
REQ-020 reset SHALL force IDLE, data register 0, counters 0 and checksum 0.
REQ-021 After reset: busy, done, readEnable and writeEnable SHALL be 0.
REQ-022 reset mid-copy SHALL abort the copy; no further writes occur and done is not pulsed.
REQ-023 The cycle counter SHALL clear on reset.

Configuration
REQ-024 With BSRAM_COPY_CHECKSUM_EN defined: checksum is cleared on accepted start, XOR-accumulates each word written, and is stable from DONE until the next accepted start.
REQ-025 Without BSRAM_COPY_CHECKSUM_EN: the checksum port is present and tied to 0, with no accumulator logic.

Verification
REQ-026 Copy test: src 0x10..0x13 = {A,B,C,D}, srcBase=0x10, dstBase=0x80, length=4 -> dst 0x80..0x83 = {A,B,C,D}; busy high 5 cycles; done one cycle later; checksum = A^B^C^D (macro on) or 0 (macro off).
REQ-027 Length 0 and 1: length=0 -> done on the next cycle with no strobes; length=1 -> exactly one write, busy high 2 cycles.
REQ-028 Wrap: srcBase=0xFE, dstBase=0xFF, length=3, nonoverlapping data -> writes to 0xFF, 0x00, 0x01 in ascending order.
REQ-029 Reset abort: reset asserted in the third STREAM cycle of a length=8 copy -> at most 2 words written, busy=0 and done=0 on the following cycle.
REQ-030 Ignored start: start pulsed during busy with different bases -> first copy completes unchanged; second request is not performed.
REQ-031 Saturation: length=0x1FF with ADDR_WIDTH=8 -> exactly 256 writes, busy high 257 cycles.

Source files
------------

// File: rtl/bsram_copy_engine.sv
// rtl/bsram_copy_engine.sv - block RAM word copy engine with registered read-to-write pipeline
// Optional checksum accumulator enabled by defining BSRAM_COPY_CHECKSUM_EN.
module bsram_copy_engine #(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] srcBase,
  input  logic [ADDR_WIDTH-1:0] dstBase,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  readEnable,
  output logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] checksum,
  input  logic                  scan
);

  localparam logic [ADDR_WIDTH:0]   MEM_DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, FILL, STREAM, DRAIN, DONE} state_t;

  state_t                  state;
  state_t                  nextState;
  logic [ADDR_WIDTH-1:0]   srcReg;
  logic [ADDR_WIDTH-1:0]   dstReg;
  logic [ADDR_WIDTH:0]     lenReg;
  logic [ADDR_WIDTH:0]     countReg;
  logic [DATA_WIDTH-1:0]   dataReg;
  logic [ADDR_WIDTH-1:0]   countLow;

  assign countLow = countReg[ADDR_WIDTH-1:0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state decode; countReg holds the index of the word being read in STREAM
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = (length == '0) ? DONE : FILL;
      FILL:    nextState = (lenReg > COUNT_ONE) ? STREAM : DRAIN;
      STREAM:  if ((countReg + COUNT_ONE) == lenReg) nextState = DRAIN;
      DRAIN:   nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request latch, word counter and read-data pipeline register
  always_ff @(posedge clock) begin
    if (reset) begin
      srcReg   <= '0;
      dstReg   <= '0;
      lenReg   <= '0;
      countReg <= '0;
      dataReg  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          srcReg   <= srcBase;
          dstReg   <= dstBase;
          lenReg   <= (length > MEM_DEPTH) ? MEM_DEPTH : length;
          countReg <= '0;
        end
        FILL, STREAM: begin
          dataReg  <= readData;
          countReg <= countReg + COUNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // Memory strobes; gated by reset so an aborting edge commits no further write
  always_comb begin
    readEnable   = 1'b0;
    writeEnable  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    readAddress  = srcReg + countLow;
    writeAddress = dstReg + countLow - ADDR_ONE;
    writeData    = dataReg;
    case (state)
      FILL: begin
        busy       = 1'b1;
        readEnable = !reset;
      end
      STREAM: begin
        busy        = 1'b1;
        readEnable  = !reset;
        writeEnable = !reset;
      end
      DRAIN: begin
        busy        = 1'b1;
        writeEnable = !reset;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

`ifdef BSRAM_COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksumReg;

  // XOR of every committed word, cleared when a new copy is accepted
  always_ff @(posedge clock) begin
    if (reset)                        checksumReg <= '0;
    else if (state == IDLE && start)  checksumReg <= '0;
    else if (writeEnable)             checksumReg <= checksumReg ^ dataReg;
  end

  assign checksum = checksumReg;
`else
  assign checksum = '0;
`endif

`ifndef SYNTHESIS
  logic [31:0] cycleCount;

  // Free-running cycle counter and per-cycle trace for simulation
  always_ff @(posedge clock) begin
    if (reset) cycleCount <= '0;
    else       cycleCount <= cycleCount + 32'd1;
    if (scan)
      $display("core %0d cycle %0d state %s rd %b @%h=%h wr %b @%h=%h",
               CORE, cycleCount, state.name(), readEnable, readAddress, readData,
               writeEnable, writeAddress, writeData);
  end
`endif

endmodule

// File: tb/tb_bsram_copy_engine.sv
// tb/tb_bsram_copy_engine.sv - randomized self-checking bench for bsram_copy_engine
module tb_bsram_copy_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  srcBase;
  logic [7:0]  dstBase;
  logic [8:0]  length;
  logic        busy;
  logic        done;
  logic        readEnable;
  logic [7:0]  readAddress;
  logic [31:0] readData;
  logic        writeEnable;
  logic [7:0]  writeAddress;
  logic [31:0] writeData;
  logic [31:0] checksum;
  logic        scan;

  logic [31:0] mem [256];
  logic [31:0] expMem [256];
  int          writeCount = 0;
  int          checks = 0;
  int          errors = 0;

  bsram_copy_engine #(.CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .srcBase(srcBase), .dstBase(dstBase),
    .length(length), .busy(busy), .done(done), .readEnable(readEnable),
    .readAddress(readAddress), .readData(readData), .writeEnable(writeEnable),
    .writeAddress(writeAddress), .writeData(writeData), .checksum(checksum), .scan(scan)
  );

  always #5 clock = ~clock;

  assign readData = mem[readAddress];

  always @(posedge clock) begin
    if (writeEnable) begin
      mem[writeAddress] <= writeData;
      writeCount <= writeCount + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " readEnable"}, readEnable, 0);
    check({tag, " writeEnable"}, writeEnable, 0);
  endtask

  task automatic checkMemory(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== expMem[i]) bad++;
    check({tag, " memory"}, bad, 0);
  endtask

  // One copy request: the model is "word i of the source (as it stood before the
  // copy) lands at dst+i, in ascending order, modulo 256"
  task automatic doCopy(input string tag, input logic [7:0] src, input logic [7:0] dst,
                        input logic [8:0] len, input int intrudeAt, input int abortAt);
    logic [7:0]  addrQ [$];
    logic [31:0] dataQ [$];
    logic [31:0] expSum = 0;
    int n = (len > 256) ? 256 : int'(len);
    int wi = 0, reads = 0, busyCnt = 0, doneAt = -1, extraBusy = 0, startWrites;

    for (int i = 0; i < n; i++) begin
      addrQ.push_back(8'(dst + i));
      dataQ.push_back(expMem[8'(src + i)]);
      expSum ^= expMem[8'(src + i)];
    end

    @(negedge clock);
    srcBase = src; dstBase = dst; length = len; start = 1'b1;
    @(negedge clock);
    start = 1'b0; srcBase = 8'($urandom); dstBase = 8'($urandom); length = 9'($urandom);
    startWrites = writeCount;

    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc == abortAt) begin
        reset = 1'b1;
        @(negedge clock);
        check({tag, " abort writes<=2"}, (writeCount - startWrites) <= 2, 1);
        check({tag, " abort busy"}, busy, 0);
        check({tag, " abort done"}, done, 0);
        for (int i = 0; i < 2 && i < n; i++) expMem[addrQ[i]] = dataQ[i];
        reset = 1'b0;
        @(negedge clock);
        checkIdle({tag, " after abort"});
        check({tag, " after abort checksum"}, checksum, 0);
        checkMemory(tag);
        return;
      end
      if (busy) busyCnt++;
      if (readEnable) reads++;
      if (writeEnable) begin
        if (wi < n) begin
          check($sformatf("%s write %0d addr", tag, wi), writeAddress, addrQ[wi]);
          check($sformatf("%s write %0d data", tag, wi), writeData, dataQ[wi]);
        end else begin
          check({tag, " unexpected write"}, 1, 0);
        end
        wi++;
      end
      if (done) begin
        doneAt = cyc;
        break;
      end
      if (cyc == intrudeAt) begin
        start = 1'b1; srcBase = src ^ 8'h40; dstBase = dst ^ 8'h20; length = 9'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;

    check({tag, " done cycle"}, doneAt, (n == 0) ? 0 : n + 1);
    check({tag, " busy cycles"}, busyCnt, (n == 0) ? 0 : n + 1);
    check({tag, " write count"}, wi, n);
    check({tag, " read count"}, reads, n);
    for (int i = 0; i < n; i++) expMem[addrQ[i]] = dataQ[i];
`ifdef BSRAM_COPY_CHECKSUM_EN
    check({tag, " checksum"}, checksum, expSum);
`else
    check({tag, " checksum"}, checksum, 0);
`endif
    @(negedge clock);
    check({tag, " done one cycle"}, done, 0);
    check({tag, " idle busy"}, busy, 0);
    if (intrudeAt >= 0) begin
      for (int i = 0; i < 8; i++) begin
        if (busy || writeEnable || readEnable) extraBusy++;
        @(negedge clock);
      end
      check({tag, " ignored start"}, extraBusy, 0);
    end
    checkMemory(tag);
  endtask

  initial begin
    logic [7:0] rs, rd;
    logic [8:0] rl;
    reset = 1'b1; start = 1'b0; scan = 1'b0;
    srcBase = '0; dstBase = '0; length = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      expMem[i] = mem[i];
    end
    repeat (3) @(negedge clock);
    checkIdle("reset");
    check("reset checksum", checksum, 0);
    reset = 1'b0;

    mem[8'h10] = 32'hA0A0_0001; expMem[8'h10] = 32'hA0A0_0001;
    mem[8'h11] = 32'hB0B0_0002; expMem[8'h11] = 32'hB0B0_0002;
    mem[8'h12] = 32'hC0C0_0004; expMem[8'h12] = 32'hC0C0_0004;
    mem[8'h13] = 32'hD0D0_0008; expMem[8'h13] = 32'hD0D0_0008;
    doCopy("copy4", 8'h10, 8'h80, 9'd4, -1, -1);

    doCopy("len0", 8'h33, 8'h44, 9'd0, -1, -1);
    scan = 1'b1;
    doCopy("len1", 8'h05, 8'hC5, 9'd1, -1, -1);
    scan = 1'b0;
    doCopy("wrap", 8'hFE, 8'hFF, 9'd3, -1, -1);
    doCopy("ignored", 8'h20, 8'h60, 9'd6, 2, -1);
    doCopy("abort", 8'h30, 8'h90, 9'd8, -1, 3);
    doCopy("saturate", 8'h00, 8'h00, 9'h1FF, -1, -1);

    for (int t = 0; t < 6; t++) begin
      rl = 9'($urandom_range(0, 128));
      rs = 8'($urandom);
      rd = 8'(rs + rl + $urandom_range(0, 256 - 2 * int'(rl)));
      doCopy($sformatf("rand%0d", t), rs, rd, rl, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
